pc_redirect_ctrl: RTL and testbench
===================================

# pc_redirect_ctrl

Control-flow redirect controller between the execute stage and fetch. It resolves jumps and taken branches in EX and computes the redirect target, either PC + ImmExt or (ALUResultE & ~1) for JALR. It holds the redirect in a pending register until fetch accepts it over a valid/ready handshake, and generates flushes for the wrong-path D and E pipeline registers. It also keeps a saturating count of redirects for performance monitoring.

## Interface
- DATA_WIDTH, 32, width of PC, immediate and ALU result
- CNT_WIDTH, 16, width of redirect counter
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid_i  in  1  EX stage holds a valid instruction this cycle
- branch_e  in  1  instruction in EX is a conditional branch
- jump_e  in  1  instruction in EX is JAL
- jalr_e  in  1  instruction in EX is JALR
- branch_taken_e  in  1  branch condition evaluated true
- pc_e  in  DATA_WIDTH  PC of the EX instruction
- imm_ext_e  in  DATA_WIDTH  sign-extended immediate
- alu_result_e  in  DATA_WIDTH  ALU result (rs1 + imm for JALR)
- redir_ready_i  in  1  fetch accepts redirect this cycle
- redir_valid_o  out  1  redirect pending toward fetch
- redir_pc_o  out  DATA_WIDTH  redirect target
- misalign_o  out  1  pending target has bit 1 set
- flush_d_o  out  1  clear IF/ID register at next edge
- flush_e_o  out  1  clear ID/EX register at next edge
- redirect_count_o  out  CNT_WIDTH  accepted resolutions, saturating

## Operation
- States: IDLE, PENDING. Reset state is IDLE.
- resolve = ex_valid_i && state==IDLE && (jalr_e || jump_e || (branch_e && branch_taken_e)).
- Target priority: jalr_e selects alu_result_e & ~1. Otherwise jump_e or a taken branch selects pc_e + imm_ext_e.
- Target arithmetic is DATA_WIDTH-bit, modulo 2^DATA_WIDTH. Carry-out is discarded, so 0xFFFFFFFC + 8 = 0x00000004.
- A branch that is not taken, or any cycle with ex_valid_i=0, causes no action.
- IDLE → PENDING on resolve. The edge captures:
  - redir_pc_q ← target
  - misalign_q ← target[1]
  - redirect_count increments, holding at all-ones.
- PENDING → IDLE at the edge where redir_valid_o && redir_ready_i.
- PENDING holds while redir_ready_i=0. redir_pc_o and misalign_o stay stable.
- While PENDING, all EX inputs are ignored, because they are wrong-path. A resolve-qualifying instruction in EX during PENDING does not update the target or the count.
- Outputs:
  - redir_valid_o = (state==PENDING)
  - redir_pc_o = redir_pc_q
  - misalign_o = misalign_q && state==PENDING
  - flush_d_o = flush_e_o = resolve || state==PENDING (combinational)
- A misaligned target is still redirected. Trap handling is outside this block.

## Timing
- Resolution cycle N: flush_d_o and flush_e_o are high in N, combinationally from the EX inputs.
- Cycle N+1: redir_valid_o and redir_pc_o are valid.
- Minimum redirect latency is 1 cycle when redir_ready_i=1 in N+1. Fetch loads the target at the N+1 edge, and the target instruction is in F at N+2.
- Flush stays high through the handshake cycle and drops the cycle after acceptance.
- Back-to-back: a new resolve is possible in the first cycle after returning to IDLE. It cannot occur in the accept cycle itself.
- Reset values, applied immediately on rst_n low (asynchronous) including mid-PENDING:
  - state = IDLE
  - redir_valid_o = 0
  - redir_pc_o = 0
  - misalign_o = 0
  - redirect_count_o = 0
  - flush_d_o and flush_e_o are 0 unless resolve holds combinationally. ex_valid_i is expected to be 0 during reset.
- The counter saturates at 2^CNT_WIDTH−1 and never wraps.

## Test plan
- JAL: pc_e=0x100, imm=0x20, ex_valid=1, ready=1.
  - Flush high in N.
  - redir_valid=1 with redir_pc=0x120 in N+1.
  - IDLE and flush low in N+2.
  - Count=1.
- JALR with alu_result=0x2003 → redir_pc=0x2002, misalign_o=1. With alu_result=0x2001 → 0x2000, misalign_o=0.
- Stall and wrong-path instructions:
  - Taken branch pc_e=0x40, imm=−8 → 0x38, with ready=0 for 5 cycles.
  - Valid, target and flush are held for all 5 cycles.
  - A JAL presented in EX during that window is ignored, and the count stays 1.
  - Accept when ready=1.
- Not-taken branch and non-control instructions: no flush, no valid, count unchanged. Also set jalr_e=jump_e=1 together → the JALR target wins.
- Wrap and saturation:
  - pc_e=0xFFFFFFFC, imm=8 → 0x00000004.
  - With CNT_WIDTH=2, four redirects leave the count at 3.
- Reset mid-PENDING: drop rst_n asynchronously between edges → redir_valid, redir_pc and count go to 0 immediately. After release, the next resolve behaves as the first.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Redirect controller between EX and fetch: resolves jumps/taken branches, holds the
// target until fetch accepts it, flushes the wrong-path D/E registers and counts redirects.
module pc_redirect_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid_i,
    input  logic                  branch_e,
    input  logic                  jump_e,
    input  logic                  jalr_e,
    input  logic                  branch_taken_e,
    input  logic [DATA_WIDTH-1:0] pc_e,
    input  logic [DATA_WIDTH-1:0] imm_ext_e,
    input  logic [DATA_WIDTH-1:0] alu_result_e,
    input  logic                  redir_ready_i,
    output logic                  redir_valid_o,
    output logic [DATA_WIDTH-1:0] redir_pc_o,
    output logic                  misalign_o,
    output logic                  flush_d_o,
    output logic                  flush_e_o,
    output logic [CNT_WIDTH-1:0]  redirect_count_o
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [0:0]            state_q;
    logic [DATA_WIDTH-1:0] redir_pc_q;
    logic                  misalign_q;
    logic [CNT_WIDTH-1:0]  count_q;

    logic                  is_pending;
    logic                  resolve;
    logic                  accept;
    logic [DATA_WIDTH-1:0] target;

    assign is_pending = (state_q == PENDING);

    // EX inputs are wrong-path while a redirect is pending, so resolution is IDLE-only.
    assign resolve = ex_valid_i && !is_pending &&
                     (jalr_e || jump_e || (branch_e && branch_taken_e));

    assign accept = is_pending && redir_ready_i;

    always_comb begin
        target = pc_e + imm_ext_e;
        if (jalr_e) begin
            target = alu_result_e & ~{{(DATA_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            redir_pc_q <= '0;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            if (resolve) begin
                state_q    <= PENDING;
                redir_pc_q <= target;
                misalign_q <= target[1];
                if (count_q != CNT_MAX) begin
                    count_q <= count_q + 1'b1;
                end
            end else if (accept) begin
                state_q <= IDLE;
            end
        end
    end

    assign redir_valid_o    = is_pending;
    assign redir_pc_o       = redir_pc_q;
    assign misalign_o       = misalign_q && is_pending;
    assign flush_d_o        = resolve || is_pending;
    assign flush_e_o        = resolve || is_pending;
    assign redirect_count_o = count_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: table of single redirects plus stall, wrong-path,
// saturation (second instance with a 2-bit counter) and asynchronous reset sequences.
module tb_pc_redirect_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ex_valid_i;
    logic        branch_e;
    logic        jump_e;
    logic        jalr_e;
    logic        branch_taken_e;
    logic [31:0] pc_e;
    logic [31:0] imm_ext_e;
    logic [31:0] alu_result_e;
    logic        redir_ready_i;

    logic        redir_valid_o;
    logic [31:0] redir_pc_o;
    logic        misalign_o;
    logic        flush_d_o;
    logic        flush_e_o;
    logic [15:0] redirect_count_o;

    logic        sat_valid;
    logic [31:0] sat_pc;
    logic        sat_misalign;
    logic        sat_flush_d;
    logic        sat_flush_e;
    logic [1:0]  sat_count;

    int checks;
    int errors;
    int exp_count;

    typedef struct {
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        taken;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] alu;
        logic        exp_resolve;
        logic [31:0] exp_pc;
        logic        exp_misalign;
    } vec_t;

    vec_t vecs[8];

    pc_redirect_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_valid_i       (ex_valid_i),
        .branch_e         (branch_e),
        .jump_e           (jump_e),
        .jalr_e           (jalr_e),
        .branch_taken_e   (branch_taken_e),
        .pc_e             (pc_e),
        .imm_ext_e        (imm_ext_e),
        .alu_result_e     (alu_result_e),
        .redir_ready_i    (redir_ready_i),
        .redir_valid_o    (redir_valid_o),
        .redir_pc_o       (redir_pc_o),
        .misalign_o       (misalign_o),
        .flush_d_o        (flush_d_o),
        .flush_e_o        (flush_e_o),
        .redirect_count_o (redirect_count_o)
    );

    pc_redirect_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut_sat (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_valid_i       (ex_valid_i),
        .branch_e         (branch_e),
        .jump_e           (jump_e),
        .jalr_e           (jalr_e),
        .branch_taken_e   (branch_taken_e),
        .pc_e             (pc_e),
        .imm_ext_e        (imm_ext_e),
        .alu_result_e     (alu_result_e),
        .redir_ready_i    (redir_ready_i),
        .redir_valid_o    (sat_valid),
        .redir_pc_o       (sat_pc),
        .misalign_o       (sat_misalign),
        .flush_d_o        (sat_flush_d),
        .flush_e_o        (sat_flush_e),
        .redirect_count_o (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkCounts(input string tag);
        checkOutput({tag, " count"}, {16'h0, redirect_count_o}, exp_count);
        checkOutput({tag, " sat_count"}, {30'h0, sat_count}, (exp_count > 3) ? 32'd3 : exp_count);
    endtask

    task automatic clearEx();
        ex_valid_i     = 1'b0;
        branch_e       = 1'b0;
        jump_e         = 1'b0;
        jalr_e         = 1'b0;
        branch_taken_e = 1'b0;
    endtask

    task automatic driveEx(input logic br, input logic jp, input logic jr, input logic tk,
                           input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] alu);
        ex_valid_i     = 1'b1;
        branch_e       = br;
        jump_e         = jp;
        jalr_e         = jr;
        branch_taken_e = tk;
        pc_e           = pc;
        imm_ext_e      = imm;
        alu_result_e   = alu;
    endtask

    // One instruction in EX for a single cycle, then immediate acceptance by fetch.
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        driveEx(v.branch, v.jump, v.jalr, v.taken, v.pc, v.imm, v.alu);
        redir_ready_i = 1'b0;
        #1;
        checkOutput({tag, " flush_d N"}, {31'h0, flush_d_o}, {31'h0, v.exp_resolve});
        checkOutput({tag, " flush_e N"}, {31'h0, flush_e_o}, {31'h0, v.exp_resolve});
        checkOutput({tag, " valid N"}, {31'h0, redir_valid_o}, 32'h0);
        @(posedge clk);
        #1;
        clearEx();
        if (v.exp_resolve) exp_count++;
        checkOutput({tag, " valid N+1"}, {31'h0, redir_valid_o}, {31'h0, v.exp_resolve});
        checkCounts(tag);
        if (v.exp_resolve) begin
            checkOutput({tag, " redir_pc"}, redir_pc_o, v.exp_pc);
            checkOutput({tag, " misalign"}, {31'h0, misalign_o}, {31'h0, v.exp_misalign});
            checkOutput({tag, " flush N+1"}, {31'h0, flush_d_o}, 32'h1);
            redir_ready_i = 1'b1;
            @(posedge clk);
            #1;
            redir_ready_i = 1'b0;
            checkOutput({tag, " valid N+2"}, {31'h0, redir_valid_o}, 32'h0);
            checkOutput({tag, " flush N+2"}, {31'h0, flush_d_o}, 32'h0);
        end else begin
            checkOutput({tag, " flush N+1"}, {31'h0, flush_d_o}, 32'h0);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_count = 0;

        //          br    jp    jr    tk    pc            imm           alu           res   exp_pc        mis
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00000100, 32'h00000020, 32'h0,        1'b1, 32'h00000120, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00000500, 32'h00000004, 32'h00002003, 1'b1, 32'h00002002, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00000500, 32'h00000004, 32'h00002001, 1'b1, 32'h00002000, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00000040, 32'hFFFFFFF8, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00000080, 32'h00000010, 32'h00000123, 1'b0, 32'h0,        1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00000100, 32'h00000020, 32'h00003007, 1'b1, 32'h00003006, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h00000008, 32'h0,        1'b1, 32'h00000004, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00000040, 32'hFFFFFFF8, 32'h0,        1'b1, 32'h00000038, 1'b0};

        rst_n         = 1'b0;
        redir_ready_i = 1'b0;
        pc_e          = '0;
        imm_ext_e     = '0;
        alu_result_e  = '0;
        clearEx();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset valid", {31'h0, redir_valid_o}, 32'h0);
        checkOutput("reset pc", redir_pc_o, 32'h0);
        checkOutput("reset flush", {31'h0, flush_d_o}, 32'h0);
        checkCounts("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Stall: taken branch held pending for 5 cycles while a JAL sits in EX.
        @(negedge clk);
        driveEx(1'b1, 1'b0, 1'b0, 1'b1, 32'h00000040, 32'hFFFFFFF8, 32'h0);
        #1;
        checkOutput("stall flush N", {31'h0, flush_e_o}, 32'h1);
        @(posedge clk);
        #1;
        exp_count++;
        driveEx(1'b0, 1'b1, 1'b0, 1'b0, 32'h00000900, 32'h00000100, 32'h0);
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("stall%0d valid", c), {31'h0, redir_valid_o}, 32'h1);
            checkOutput($sformatf("stall%0d pc", c), redir_pc_o, 32'h00000038);
            checkOutput($sformatf("stall%0d flush", c), {31'h0, flush_d_o}, 32'h1);
            @(posedge clk);
            #1;
        end
        checkCounts("stall");
        clearEx();
        redir_ready_i = 1'b1;
        @(posedge clk);
        #1;
        redir_ready_i = 1'b0;
        checkOutput("stall accept valid", {31'h0, redir_valid_o}, 32'h0);
        checkOutput("stall accept flush", {31'h0, flush_d_o}, 32'h0);
        checkCounts("stall accept");

        // Asynchronous reset while a redirect is pending.
        @(negedge clk);
        driveEx(1'b0, 1'b1, 1'b0, 1'b0, 32'h00000200, 32'h00000010, 32'h0);
        @(posedge clk);
        #1;
        clearEx();
        checkOutput("prerst valid", {31'h0, redir_valid_o}, 32'h1);
        checkOutput("prerst pc", redir_pc_o, 32'h00000210);
        #2;
        rst_n = 1'b0;
        #1;
        exp_count = 0;
        checkOutput("async rst valid", {31'h0, redir_valid_o}, 32'h0);
        checkOutput("async rst pc", redir_pc_o, 32'h0);
        checkOutput("async rst flush", {31'h0, flush_d_o}, 32'h0);
        checkCounts("async rst");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(vecs[1], 101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
